// File: rtl/cmp_lt_share_sched_if.sv
// Request/response bundle for the shared less-than comparator: per-requester operand
// buses with valid/ready, and a single tagged result channel with valid/ready.
interface cmp_lt_share_sched_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_res;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_res
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_res
    );
endinterface

// File: rtl/cmp_lt_share_sched.sv
// Round-robin scheduler sharing one unsigned a<b comparator among NREQ requesters;
// LE/GT/GE are folded onto the LT core by operand swap and result inversion at latch time.
module cmp_lt_share_sched #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmp_lt_share_sched_if.slave     bus,
    output logic [CNTW-1:0]         cmp_count
);
    localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_e;

    state_e           state_q, state_d;
    logic [SELW-1:0]  last_q, last_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             inv_q, inv_d;
    logic             res_q, res_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [1:0]       op_arr [NREQ];

    logic             grant_en;
    logic             win_any;
    logic [SELW-1:0]  win_sel;
    logic [SELW-1:0]  cand;
    logic [NREQ-1:0]  ready_c;
    logic             hs;
    logic [1:0]       win_op;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = bus.req_a[i*WIDTH +: WIDTH];
            b_arr[i]  = bus.req_b[i*WIDTH +: WIDTH];
            op_arr[i] = bus.req_op[i*2 +: 2];
        end
    end

    // Search starts one past the last winner, so the previous owner has lowest priority.
    always_comb begin
        grant_en = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
        win_any  = 1'b0;
        win_sel  = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SELW'((int'(last_q) + k) % NREQ);
            if (!win_any && bus.req_valid[cand]) begin
                win_any = 1'b1;
                win_sel = cand;
            end
        end
        ready_c = '0;
        if (grant_en && win_any) begin
            ready_c[win_sel] = 1'b1;
        end
        hs = |ready_c;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        inv_d   = inv_q;
        res_d   = res_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        win_op  = op_arr[win_sel];

        unique case (state_q)
            IDLE: if (hs) state_d = CMP;
            CMP:  begin
                res_d   = (x_q < y_q) ^ inv_q;
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = hs ? CMP : IDLE;
            default: state_d = IDLE;
        endcase

        // LE and GT swap operands; LE and GE invert the core result.
        if (hs) begin
            x_d    = (win_op[1] ^ win_op[0]) ? b_arr[win_sel] : a_arr[win_sel];
            y_d    = (win_op[1] ^ win_op[0]) ? a_arr[win_sel] : b_arr[win_sel];
            inv_d  = win_op[0];
            id_d   = IDW'(win_sel);
            last_d = win_sel;
        end

        if ((state_q == RESP) && bus.rsp_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SELW'(NREQ - 1);
            x_q     <= '0;
            y_q     <= '0;
            inv_q   <= 1'b0;
            res_q   <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_res   = res_q;
    assign cmp_count     = cnt_q;
endmodule

// File: tb/tb_cmp_lt_share_sched.sv
// Scoreboard bench for cmp_lt_share_sched: stimulus pushes expected {id,res,due cycle}
// on each observed grant; a negedge monitor pops and compares on each presented response.
module tb_cmp_lt_share_sched;
    localparam int W = 32;
    localparam int N = 4;
    localparam int I = 2;
    localparam int C = 4;
    localparam logic [1:0] OP_LT = 2'd0, OP_LE = 2'd1, OP_GT = 2'd2, OP_GE = 2'd3;

    typedef struct {
        logic [I-1:0] id;
        logic         res;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [C-1:0] cmp_count;

    cmp_lt_share_sched_if #(.WIDTH(W), .NREQ(N), .IDW(I)) bus ();

    cmp_lt_share_sched #(.WIDTH(W), .NREQ(N), .IDW(I), .CNTW(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cmp_count (cmp_count)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   exp_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    logic [I-1:0] prev_id = '0;
    logic prev_res = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            OP_LT:   return a < b;
            OP_LE:   return a <= b;
            OP_GT:   return a > b;
            default: return a >= b;
        endcase
    endfunction

    // Response monitor: new responses are compared against the scoreboard head,
    // stalled ones must hold their payload, and cmp_count is tracked with saturation.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt    = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (!prev_valid || prev_hs) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rsp: got id %0d res %0d with no request outstanding (cycle %0d)",
                                 bus.rsp_id, bus.rsp_res, cyc);
                    end else begin
                        check("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
                        check("rsp_res", 64'(bus.rsp_res), 64'(sb[0].res));
                        check("rsp_latency_cycle", 64'(cyc), 64'(sb[0].due));
                    end
                end else begin
                    check("hold_rsp_id", 64'(bus.rsp_id), 64'(prev_id));
                    check("hold_rsp_res", 64'(bus.rsp_res), 64'(prev_res));
                end
                if (bus.rsp_ready) begin
                    check("cmp_count_before_hs", 64'(cmp_count), 64'(exp_cnt));
                    if (sb.size() > 0) void'(sb.pop_front());
                    if (exp_cnt < (1 << C) - 1) exp_cnt++;
                end
            end
            prev_valid = bus.rsp_valid;
            prev_hs    = bus.rsp_valid && bus.rsp_ready;
            prev_id    = bus.rsp_id;
            prev_res   = bus.rsp_res;
        end
    end

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        bus.req_a[id*W +: W]  = a;
        bus.req_b[id*W +: W]  = b;
        bus.req_op[id*2 +: 2] = op;
        bus.req_valid[id]     = 1'b1;
    endtask

    task automatic await_grant(input int id, input logic res, input bit push);
        bit got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (|bus.req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: req %0d got no req_ready within 20 cycles", id);
        end else begin
            check("grant_onehot", 64'(bus.req_ready), 64'(1) << id);
            gnt_cyc = cyc;
            if (push) sb.push_back('{id: I'(id), res: res, due: cyc + 2});
        end
    endtask

    task automatic drop(input int id);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic res);
        drive(id, a, b, op);
        await_grant(id, res, 1'b1);
        drop(id);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.rsp_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [W-1:0] sw_a [8] = '{32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [W-1:0] sw_b [8] = '{32'h1234, 32'h1234, 32'h1234, 32'h1234,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [1:0]   sw_op[8] = '{OP_LT, OP_LE, OP_GT, OP_GE, OP_GT, OP_GE, OP_LT, OP_LE};
    logic         sw_res[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic [W-1:0] rr_a  [4] = '{32'd0, 32'd10, 32'd20, 32'd30};
    logic [1:0]   rr_op [4] = '{OP_LT, OP_GE, OP_LE, OP_GT};
    logic         rr_res[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int           rr_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("reset_rsp_res", 64'(bus.rsp_res), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        check("reset_cmp_count", 64'(cmp_count), 64'd0);
        reset_dut();

        // 1: single request
        do_req(0, 32'd5, 32'd9, OP_LT, 1'b1);
        drain();
        check("t1_cmp_count", 64'(cmp_count), 64'd1);

        // 2: op sweep on equal operands and on unsigned extremes
        for (int i = 0; i < 8; i++) do_req(1, sw_a[i], sw_b[i], sw_op[i], sw_res[i]);
        drain();
        check("t2_cmp_count", 64'(cmp_count), 64'd9);

        // 3: round-robin with all requesters asserting
        reset_dut();
        for (int i = 0; i < 4; i++) drive(i, rr_a[i], 32'd25, rr_op[i]);
        for (int g = 0; g < 5; g++) begin
            int prev_g;
            prev_g = gnt_cyc;
            await_grant(rr_ord[g], rr_res[rr_ord[g]], 1'b1);
            if (g > 0) check("rr_grant_spacing", 64'(gnt_cyc - prev_g), 64'd2);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain();
        check("t3_cmp_count", 64'(cmp_count), 64'd5);

        // 4: backpressure for 5 cycles, then same-cycle regrant on release
        bus.rsp_ready = 1'b0;
        do_req(2, 32'd100, 32'd7, OP_GE, 1'b1);
        drive(1, 32'd3, 32'd3, OP_LT);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        await_grant(1, 1'b0, 1'b1);
        check("bp_release_same_cycle", 64'(gnt_cyc), 64'(cyc));
        drop(1);
        drain();
        check("t4_cmp_count", 64'(cmp_count), 64'd7);

        // 5: reset while a compare is in flight
        drive(1, 32'd50, 32'd60, OP_GT);
        await_grant(1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_cmp_count", 64'(cmp_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        drive(3, 32'd8, 32'd8, OP_LE);
        drive(0, 32'hFFFF_FFFF, 32'd0, OP_GT);
        await_grant(0, 1'b1, 1'b1);
        drop(0);
        await_grant(3, 1'b1, 1'b1);
        drop(3);

        // 6: counter saturation (20 compares since reset, 4-bit counter)
        for (int i = 0; i < 18; i++) begin
            logic [W-1:0] a, b;
            logic [1:0]   op;
            a  = W'(i * 7);
            b  = W'(50 - i * 2);
            op = 2'(i % 4);
            do_req(i % 4, a, b, op, rel(a, b, op));
        end
        drain();
        check("t6_cmp_count_saturated", 64'(cmp_count), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
